// File: rtl/user_input_pulse_array.sv
// Multi-channel key conditioner: 2-flop sync, debounce, one-clock press pulse per channel.
// Optional auto-repeat while a key stays held is enabled by defining USER_INPUT_REPEAT_EN.
module user_input_pulse_array #(
    parameter int CHANNELS        = 4,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic                Clock,
    input  logic                Reset,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] held
);

    // state    | meaning
    // RELEASED | debounced key up, held = 0
    // PRESSED  | debounced key down, held = 1
    localparam logic [0:0] RELEASED = 1'b0;
    localparam logic [0:0] PRESSED  = 1'b1;

    localparam int   CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic IDLE_LEVEL = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("user_input_pulse_array: all size/timing parameters must be >= 1");
    end

    logic [CHANNELS-1:0] sync1_q, sync1_d;
    logic [CHANNELS-1:0] sync2_q, sync2_d;
    logic [CHANNELS-1:0] state_q, state_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] pressed;
    logic [CHANNELS-1:0] rise;
    logic [CHANNELS-1:0] fall;
    logic [CW-1:0]       cnt_q [CHANNELS];
    logic [CW-1:0]       cnt_d [CHANNELS];

    always_comb begin
        sync1_d = in;
        sync2_d = sync1_q;
        pressed = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
        state_d = state_q;
        rise    = '0;
        fall    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i] = '0;
            // Counter only runs while the sample disagrees with the accepted level.
            if (pressed[i] != state_q[i]) begin
                if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
                    case (state_q[i])
                        RELEASED: begin
                            state_d[i] = PRESSED;
                            rise[i]    = 1'b1;
                        end
                        default: begin
                            state_d[i] = RELEASED;
                            fall[i]    = 1'b1;
                        end
                    endcase
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

`ifdef USER_INPUT_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0]       rpt_q [CHANNELS];
    logic [RW-1:0]       rpt_d [CHANNELS];
    logic [CHANNELS-1:0] rearm_q, rearm_d;
    logic [CHANNELS-1:0] rpt_fire;

    // rearm selects the target: first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD.
    always_comb begin
        rearm_d  = '0;
        rpt_fire = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            rpt_d[i] = '0;
            if (state_q[i] == PRESSED && !fall[i]) begin
                if (rpt_q[i] == (rearm_q[i] ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
                    rpt_fire[i] = 1'b1;
                    rearm_d[i]  = 1'b1;
                end else begin
                    rpt_d[i]   = rpt_q[i] + RW'(1);
                    rearm_d[i] = rearm_q[i];
                end
            end
        end
        out_d = rise | rpt_fire;
    end
`else
    always_comb begin
        out_d = rise;
    end
`endif

    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync1_q <= {CHANNELS{IDLE_LEVEL}};
            sync2_q <= {CHANNELS{IDLE_LEVEL}};
            state_q <= {CHANNELS{RELEASED}};
            out_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= '0;
            end
`ifdef USER_INPUT_REPEAT_EN
            rearm_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                rpt_q[i] <= '0;
            end
`endif
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            state_q <= state_d;
            out_q   <= out_d;
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
`ifdef USER_INPUT_REPEAT_EN
            rearm_q <= rearm_d;
            for (int i = 0; i < CHANNELS; i++) begin
                rpt_q[i] <= rpt_d[i];
            end
`endif
        end
    end

    assign out  = out_q;
    assign held = state_q;

endmodule

// File: tb/tb_user_input_pulse_array.sv
// Directed bench for user_input_pulse_array: an active-low instance and an active-high instance.
module tb_user_input_pulse_array;

    logic       Clock;
    logic       Reset;
    logic [3:0] in_a, out_a, held_a;
    logic [3:0] in_b, out_b, held_b;
    int         checks;
    int         errors;

    user_input_pulse_array #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(1),
                             .REPEAT_DELAY(16), .REPEAT_PERIOD(4)) dut_a (
        .Clock(Clock), .Reset(Reset), .in(in_a), .out(out_a), .held(held_a)
    );

    user_input_pulse_array #(.CHANNELS(4), .DEBOUNCE_CYCLES(4), .ACTIVE_LOW(0),
                             .REPEAT_DELAY(16), .REPEAT_PERIOD(4)) dut_b (
        .Clock(Clock), .Reset(Reset), .in(in_b), .out(out_b), .held(held_b)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        in_a  = 4'hF;
        in_b  = 4'h0;
        repeat (3) step();
        checks += 4;
        if (out_a !== 4'h0) begin errors++; $display("FAIL reset_out_a got %b want 0000", out_a); end
        if (held_a !== 4'h0) begin errors++; $display("FAIL reset_held_a got %b want 0000", held_a); end
        if (out_b !== 4'h0) begin errors++; $display("FAIL reset_out_b got %b want 0000", out_b); end
        if (held_b !== 4'h0) begin errors++; $display("FAIL reset_held_b got %b want 0000", held_b); end
        Reset = 1'b0;
        repeat (10) step();
        checks += 2;
        if (out_a !== 4'h0 || held_a !== 4'h0) begin
            errors++; $display("FAIL idle_a out %b held %b want 0000", out_a, held_a);
        end
        if (out_b !== 4'h0 || held_b !== 4'h0) begin
            errors++; $display("FAIL idle_b out %b held %b want 0000", out_b, held_b);
        end
    endtask

    task automatic test_press_release();
        logic [3:0] exp_out, exp_held;
        in_a[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_out  = (k == 5) ? 4'b0001 : 4'b0000;
            exp_held = (k >= 5) ? 4'b0001 : 4'b0000;
            checks += 2;
            if (out_a !== exp_out) begin errors++; $display("FAIL press_out edge %0d got %b want %b", k, out_a, exp_out); end
            if (held_a !== exp_held) begin errors++; $display("FAIL press_held edge %0d got %b want %b", k, held_a, exp_held); end
        end
        in_a[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_held = (k < 5) ? 4'b0001 : 4'b0000;
            checks += 2;
            if (out_a !== 4'b0000) begin errors++; $display("FAIL release_out edge %0d got %b want 0000", k, out_a); end
            if (held_a !== exp_held) begin errors++; $display("FAIL release_held edge %0d got %b want %b", k, held_a, exp_held); end
        end
    endtask

    task automatic test_glitch();
        in_a[1] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (k == 3) in_a[1] = 1'b1;
            step();
            checks++;
            if (out_a !== 4'b0000 || held_a !== 4'b0000) begin
                errors++; $display("FAIL glitch edge %0d out %b held %b want 0000", k, out_a, held_a);
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [3:0] exp_out, exp_held;
        in_a[0] = 1'b0;
        in_a[3] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_out  = (k == 5) ? 4'b1001 : 4'b0000;
            exp_held = (k >= 5) ? 4'b1001 : 4'b0000;
            checks += 2;
            if (out_a !== exp_out) begin errors++; $display("FAIL simul_out edge %0d got %b want %b", k, out_a, exp_out); end
            if (held_a !== exp_held) begin errors++; $display("FAIL simul_held edge %0d got %b want %b", k, held_a, exp_held); end
        end
        in_a[0] = 1'b1;
        in_a[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            checks++;
            if (out_a !== 4'b0000) begin errors++; $display("FAIL simul_release_out edge %0d got %b want 0000", k, out_a); end
        end
        checks++;
        if (held_a !== 4'b0000) begin errors++; $display("FAIL simul_release_held got %b want 0000", held_a); end
    endtask

    task automatic test_long_hold();
        logic       exp;
        logic [3:0] exp_out;
        int         pulses;
        int         exp_pulses;
        pulses = 0;
        for (int e = 0; e < 112; e++) begin
            in_a[2] = (e < 100) ? 1'b0 : 1'b1;
            step();
            exp = (e == 5);
`ifdef USER_INPUT_REPEAT_EN
            if (e >= 21 && e < 105 && ((e - 21) % 4) == 0) exp = 1'b1;
`endif
            exp_out = {1'b0, exp, 2'b00};
            if (out_a[2]) pulses++;
            checks += 2;
            if (out_a !== exp_out) begin errors++; $display("FAIL hold_out edge %0d got %b want %b", e, out_a, exp_out); end
            if (held_a[2] !== (e >= 5 && e < 105)) begin
                errors++; $display("FAIL hold_held edge %0d got %b want %b", e, held_a[2], (e >= 5 && e < 105));
            end
        end
`ifdef USER_INPUT_REPEAT_EN
        exp_pulses = 22;
`else
        exp_pulses = 1;
`endif
        checks++;
        if (pulses !== exp_pulses) begin errors++; $display("FAIL hold_pulse_count got %0d want %0d", pulses, exp_pulses); end
    endtask

    task automatic test_reset_mid_debounce();
        logic [3:0] exp_out;
        in_a[1] = 1'b0;
        repeat (4) step();
        Reset = 1'b1;
        repeat (2) step();
        checks += 2;
        if (held_a !== 4'b0000) begin errors++; $display("FAIL midrst_held got %b want 0000", held_a); end
        if (out_a !== 4'b0000) begin errors++; $display("FAIL midrst_out got %b want 0000", out_a); end
        Reset = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_out = (k == 5) ? 4'b0010 : 4'b0000;
            checks++;
            if (out_a !== exp_out) begin errors++; $display("FAIL midrst_pulse edge %0d got %b want %b", k, out_a, exp_out); end
        end
        in_a[1] = 1'b1;
        repeat (8) step();
        checks++;
        if (held_a !== 4'b0000) begin errors++; $display("FAIL midrst_release got %b want 0000", held_a); end
    endtask

    task automatic test_active_high();
        logic [3:0] exp_out, exp_held;
        in_b[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            exp_out  = (k == 5) ? 4'b0100 : 4'b0000;
            exp_held = (k >= 5) ? 4'b0100 : 4'b0000;
            checks += 2;
            if (out_b !== exp_out) begin errors++; $display("FAIL ahigh_out edge %0d got %b want %b", k, out_b, exp_out); end
            if (held_b !== exp_held) begin errors++; $display("FAIL ahigh_held edge %0d got %b want %b", k, held_b, exp_held); end
        end
        in_b[2] = 1'b0;
        repeat (8) step();
        checks++;
        if (held_b !== 4'b0000) begin errors++; $display("FAIL ahigh_release got %b want 0000", held_b); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        Reset  = 1'b1;
        in_a   = 4'hF;
        in_b   = 4'h0;
        test_reset();
        test_press_release();
        test_glitch();
        test_simultaneous();
        test_long_hold();
        test_reset_mid_debounce();
        test_active_high();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
